// File: rtl/fixed_linear_weight_source.sv
// Weight source for a fixed_linear consumer: holds a BEATS x BEAT_W weight
// memory and streams it in transposed, partitioned beat order for `rows`
// passes per start, through a 2-entry skid buffer with valid/ready.
// Optional macro WEIGHT_SOURCE_LAST_EN adds the weight_last port, which marks
// the final input-depth beat of each output group.
module fixed_linear_weight_source #(
  parameter int unsigned WEIGHT_PRECISION_0          = 16,
  parameter int unsigned WEIGHT_TENSOR_SIZE_DIM_0    = 4,
  parameter int unsigned WEIGHT_TENSOR_SIZE_DIM_1    = 4,
  parameter int unsigned WEIGHT_PARALLELISM_DIM_0    = 2,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0 = 2,
  parameter int unsigned MAX_ROWS                    = 256,
  localparam int unsigned IN_DEPTH  = WEIGHT_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0,
  localparam int unsigned OUT_DEPTH = WEIGHT_TENSOR_SIZE_DIM_1 / WEIGHT_PARALLELISM_DIM_0,
  localparam int unsigned BEATS     = IN_DEPTH * OUT_DEPTH,
  localparam int unsigned NE        = WEIGHT_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_0,
  localparam int unsigned BEAT_W    = NE * WEIGHT_PRECISION_0,
  localparam int unsigned AW        = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned RW        = $clog2(MAX_ROWS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [BEAT_W-1:0]             wr_data,
  input  logic                          start,
  input  logic [RW-1:0]                 rows,
  output logic                          busy,
  output logic                          done,
  output logic [WEIGHT_PRECISION_0-1:0] weight [NE],
  output logic                          weight_valid,
  input  logic                          weight_ready
`ifdef WEIGHT_SOURCE_LAST_EN
  ,
  output logic                          weight_last
`endif
);

  localparam int unsigned W  = WEIGHT_PRECISION_0;
  localparam int unsigned DW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int unsigned OW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned TW = $clog2(MAX_ROWS * BEATS + 1);

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, DONE} state_t;

  state_t            state;
  logic [BEAT_W-1:0] mem [BEATS];
  logic [BEAT_W-1:0] rd_data;
  logic [BEAT_W-1:0] head_q;
  logic [BEAT_W-1:0] skid_q;
  logic              rd_v;
  logic [1:0]        cnt_q;
  logic [RW-1:0]     rows_q;
  logic [RW-1:0]     row_cnt;
  logic [DW-1:0]     d_cnt;
  logic [OW-1:0]     o_cnt;
  logic [TW-1:0]     iss_cnt;
  logic [AW-1:0]     rd_addr;
`ifdef WEIGHT_SOURCE_LAST_EN
  logic [DW-1:0]     iss_d;
  logic              rd_last;
  logic              skid_last;
`endif

  logic              pop_c;
  logic              issue_c;
  logic              final_c;
  logic [2:0]        occ_c;
  logic [TW-1:0]     total_c;
  logic [RW-1:0]     rows_clamp_c;

  // Handshake, read-issue credit and end-of-stream detection
  always_comb begin
    pop_c        = weight_valid & weight_ready;
    occ_c        = 3'(cnt_q) + 3'(rd_v) - 3'(pop_c);
    total_c      = TW'(rows_q) * TW'(BEATS);
    issue_c      = ((state == PREFETCH) || (state == STREAM)) &&
                   (iss_cnt < total_c) && (occ_c < 3'd2);
    final_c      = pop_c && (d_cnt == DW'(IN_DEPTH - 1)) &&
                   (o_cnt == OW'(OUT_DEPTH - 1)) && (row_cnt == rows_q - RW'(1));
    rows_clamp_c = (rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : rows;
  end

  // Weight memory: write only while idle, registered read; not reset
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE)) mem[wr_addr] <= wr_data;
    if (issue_c) rd_data <= mem[rd_addr];
  end

  // Control FSM, read pipeline, skid buffer and beat counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      weight_valid <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
      rd_v         <= 1'b0;
      cnt_q        <= '0;
      rows_q       <= '0;
      row_cnt      <= '0;
      d_cnt        <= '0;
      o_cnt        <= '0;
      iss_cnt      <= '0;
      rd_addr      <= '0;
`ifdef WEIGHT_SOURCE_LAST_EN
      iss_d        <= '0;
      rd_last      <= 1'b0;
      skid_last    <= 1'b0;
      weight_last  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rows_q  <= rows_clamp_c;
            row_cnt <= '0;
            d_cnt   <= '0;
            o_cnt   <= '0;
            iss_cnt <= '0;
            rd_addr <= '0;
`ifdef WEIGHT_SOURCE_LAST_EN
            iss_d   <= '0;
`endif
            busy    <= 1'b1;
            if (rows_clamp_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= PREFETCH;
            end
          end
        end
        PREFETCH: state <= STREAM;
        STREAM: begin
          if (final_c) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      rd_v <= issue_c;
      if (issue_c) begin
        iss_cnt <= iss_cnt + TW'(1);
        rd_addr <= (rd_addr == AW'(BEATS - 1)) ? '0 : rd_addr + AW'(1);
`ifdef WEIGHT_SOURCE_LAST_EN
        rd_last <= (iss_d == DW'(IN_DEPTH - 1));
        iss_d   <= (iss_d == DW'(IN_DEPTH - 1)) ? '0 : iss_d + DW'(1);
`endif
      end

      cnt_q        <= occ_c[1:0];
      weight_valid <= (occ_c != 3'd0);
      if (rd_v && !pop_c) begin
        if (cnt_q == 2'd0) begin
          head_q <= rd_data;
`ifdef WEIGHT_SOURCE_LAST_EN
          weight_last <= rd_last;
`endif
        end else begin
          skid_q <= rd_data;
`ifdef WEIGHT_SOURCE_LAST_EN
          skid_last <= rd_last;
`endif
        end
      end else if (!rd_v && pop_c) begin
        if (cnt_q == 2'd2) begin
          head_q <= skid_q;
`ifdef WEIGHT_SOURCE_LAST_EN
          weight_last <= skid_last;
`endif
        end else begin
`ifdef WEIGHT_SOURCE_LAST_EN
          weight_last <= 1'b0;
`endif
        end
      end else if (rd_v && pop_c) begin
        if (cnt_q == 2'd2) begin
          head_q <= skid_q;
          skid_q <= rd_data;
`ifdef WEIGHT_SOURCE_LAST_EN
          weight_last <= skid_last;
          skid_last   <= rd_last;
`endif
        end else begin
          head_q <= rd_data;
`ifdef WEIGHT_SOURCE_LAST_EN
          weight_last <= rd_last;
`endif
        end
      end

      if (pop_c) begin
        if (d_cnt == DW'(IN_DEPTH - 1)) begin
          d_cnt <= '0;
          if (o_cnt == OW'(OUT_DEPTH - 1)) begin
            o_cnt   <= '0;
            row_cnt <= row_cnt + RW'(1);
          end else begin
            o_cnt <= o_cnt + OW'(1);
          end
        end else begin
          d_cnt <= d_cnt + DW'(1);
        end
      end
    end
  end

  // Unpack the head beat onto the element ports
  for (genvar g = 0; g < int'(NE); g++) begin : g_unpack
    assign weight[g] = head_q[g*W +: W];
  end

endmodule

// File: tb/tb_fixed_linear_weight_source.sv
// Randomized self-checking bench for fixed_linear_weight_source (W=8, 4x4
// weights, 2x2 parallelism, MAX_ROWS=5). Reference is a weight matrix plus a
// queue of expected beats derived from it.
module tb_fixed_linear_weight_source;

  localparam int unsigned MAXR = 5;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [31:0] wr_data;
  logic       start;
  logic [2:0] rows;
  logic       busy;
  logic       done;
  logic [7:0] weight [4];
  logic       weight_valid;
  logic       weight_ready;
`ifdef WEIGHT_SOURCE_LAST_EN
  logic       weight_last;
`endif

  fixed_linear_weight_source #(
    .WEIGHT_PRECISION_0(8),
    .WEIGHT_TENSOR_SIZE_DIM_0(4),
    .WEIGHT_TENSOR_SIZE_DIM_1(4),
    .WEIGHT_PARALLELISM_DIM_0(2),
    .DATA_IN_0_PARALLELISM_DIM_0(2),
    .MAX_ROWS(MAXR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .rows(rows),
    .busy(busy),
    .done(done),
    .weight(weight),
    .weight_valid(weight_valid),
    .weight_ready(weight_ready)
`ifdef WEIGHT_SOURCE_LAST_EN
    ,
    .weight_last(weight_last)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: weight matrix W[out][in] and queue of expected beats
  typedef struct {
    int          k;
    logic [31:0] d;
  } beat_t;

  logic [7:0] wm [4][4];
  beat_t      q[$];
  bit         m_active = 0;
  int         m_first  = 0;
  int         m_done_at = -1;

  function automatic logic [31:0] beat_of(input int k);
    logic [31:0] r;
    int o = k / 2;
    int dd = k % 2;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r[(2*i+j)*8 +: 8] = wm[o*2+i][dd*2+j];
    return r;
  endfunction

  function automatic void write_beat(input int k, input logic [31:0] data);
    int o = k / 2;
    int dd = k % 2;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        wm[o*2+i][dd*2+j] = data[(2*i+j)*8 +: 8];
  endfunction

  // Ready pattern generator: 0 always high, 1 pattern 1,0,0,1, 2 random
  int rmode = 0;
  initial begin
    logic pat [4];
    int idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    idx = 0;
    weight_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rmode)
        1:       begin weight_ready = pat[idx % 4]; idx++; end
        2:       weight_ready = 1'($urandom_range(0, 1));
        default: weight_ready = 1'b1;
      endcase
    end
  end

  // Per-cycle model update and output comparison
  initial begin
    int n;
    bit pv;
    bit exp_v;
    bit acc;
    bit wr;
    int r;
    logic [31:0] act;
    n = 0;
    pv = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (!rst) begin
        q.delete();
        m_active  = 0;
        m_done_at = -1;
        pv        = 0;
        continue;
      end
      if (pv && weight_ready) begin
        if (q.size() == 0) begin
          chk("spurious_handshake", 32'd1, 32'd0);
        end else begin
          void'(q.pop_front());
          if (q.size() == 0) m_done_at = n;
        end
      end
      acc = start && !m_active;
      wr  = wr_en && !m_active;
      if (m_active && m_done_at >= 0 && n == m_done_at + 1) m_active = 0;
      if (wr) write_beat(int'(wr_addr), wr_data);
      if (acc) begin
        r = (int'(rows) > int'(MAXR)) ? int'(MAXR) : int'(rows);
        for (int p = 0; p < r; p++)
          for (int k = 0; k < 4; k++) q.push_back('{k: k, d: beat_of(k)});
        m_active  = 1;
        m_first   = n + 2;
        m_done_at = (r == 0) ? n : -1;
      end
      exp_v = m_active && (q.size() > 0) && (n >= m_first);
      chk("valid", 32'(weight_valid), 32'(exp_v));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(n == m_done_at));
      if (exp_v && weight_valid) begin
        for (int e = 0; e < 4; e++) act[e*8 +: 8] = weight[e];
        chk("beat_data", act, q[0].d);
      end
`ifdef WEIGHT_SOURCE_LAST_EN
      chk("last", 32'(weight_last), 32'(exp_v && (q.size() > 0) && (q[0].k % 2 == 1)));
`endif
      pv = weight_valid;
    end
  end

  task automatic start_run(input int r, input bit w, input int a, input logic [31:0] dat);
    start   = 1'b1;
    rows    = 3'(r);
    wr_en   = w;
    wr_addr = 2'(a);
    wr_data = dat;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (m_active && c < budget);
    if (m_active) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int c;
    rst = 1'b0;
    start = 1'b0;
    rows = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) wm[i][j] = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(weight_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Load pattern: element n of beat k = 0x10*n + k
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1;
      wr_addr = 2'(k);
      wr_data = {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k), 8'(k)};
      @(negedge clk);
    end
    wr_en = 1'b0;

    // Single pass, latency and literal beat contents
    start_run(1, 0, 0, 32'h0);
    @(posedge clk); #1;
    chk("t1_no_valid_yet", 32'(weight_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_first_valid", 32'(weight_valid), 32'd1);
    chk("t1_b0e0", 32'(weight[0]), 32'h00);
    chk("t1_b0e3", 32'(weight[3]), 32'h30);
`ifdef WEIGHT_SOURCE_LAST_EN
    chk("t1_last_b0", 32'(weight_last), 32'd0);
`endif
    @(posedge clk); #1;
    chk("t1_b1e2", 32'(weight[2]), 32'h21);
`ifdef WEIGHT_SOURCE_LAST_EN
    chk("t1_last_b1", 32'(weight_last), 32'd1);
`endif
    wait_idle(100);

    // Three passes back to back
    start_run(3, 0, 0, 32'h0);
    wait_idle(200);

    // Backpressure pattern 1,0,0,1
    rmode = 1;
    start_run(2, 0, 0, 32'h0);
    wait_idle(200);
    rmode = 0;

    // rows=0: immediate done, no beats
    start_run(0, 0, 0, 32'h0);
    chk("t4_done_rows0", 32'(done), 32'd1);
    chk("t4_novalid_rows0", 32'(weight_valid), 32'd0);
    wait_idle(20);

    // start and write during STREAM are ignored
    start_run(2, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    start = 1'b1; rows = 3'd1;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_idle(200);
    start_run(1, 0, 0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t4_mem_kept_e0", 32'(weight[0]), 32'h00);
    chk("t4_mem_kept_e1", 32'(weight[1]), 32'h10);
    wait_idle(100);

    // Reset while beat 2 is on the output
    start_run(2, 0, 0, 32'h0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(m_active && q.size() == 6) && c < 200);
    chk("t5_reached_beat2", 32'(q.size()), 32'd6);
    rst = 1'b0;
    #1;
    chk("t5_async_valid", 32'(weight_valid), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_done", 32'(done), 32'd0);
    chk("t5_async_w0", 32'(weight[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    start_run(1, 0, 0, 32'h0);
    wait_idle(100);

    // rows above MAX_ROWS clamps
    start_run(7, 0, 0, 32'h0);
    wait_idle(300);

    // Randomized runs: writes, same-cycle write with start, ready modes
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 3)) begin
        wr_en = 1'b1;
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = $urandom;
        @(negedge clk);
      end
      wr_en = 1'b0;
      rmode = int'($urandom_range(0, 2));
      start_run(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), $urandom);
      wait_idle(2000);
    end
    rmode = 0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fixed_linear_weight_source.md
FIXED_LINEAR_WEIGHT_SOURCE -- requirements
Module: fixed_linear_weight_source

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WEIGHT_PRECISION_0, 16, element width.
- WEIGHT_TENSOR_SIZE_DIM_0, 4, input features.
- WEIGHT_TENSOR_SIZE_DIM_1, 4, output features.
- WEIGHT_PARALLELISM_DIM_0, 2, output features per beat (P_OUT).
- DATA_IN_0_PARALLELISM_DIM_0, 2, input features per beat (P_IN).
- MAX_ROWS, 256, maximum passes per start.
REQ-002 Derived values:
- IN_DEPTH = DIM_0 / P_IN.
- OUT_DEPTH = DIM_1 / P_OUT.
- BEATS = IN_DEPTH * OUT_DEPTH.
- BEAT_W = P_OUT * P_IN * WEIGHT_PRECISION_0.
REQ-003 Ports SHALL be:
- clk, input, 1, clock.
- rst, input, 1, reset; one clock, asynchronous, active-low.
- wr_en, input, 1, write one beat into weight memory.
- wr_addr, input, clog2(BEATS), beat address.
- wr_data, input, BEAT_W, beat contents.
- start, input, 1, begin streaming.
- rows, input, clog2(MAX_ROWS+1), number of full passes to stream, sampled with start.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle pulse after the last beat handshakes.
- weight, output, [WEIGHT_PRECISION_0-1:0] x (P_OUT*P_IN), unpacked beat.
- weight_valid, output, 1, beat valid.
- weight_ready, input, 1, consumer ready.

Function
REQ-004 Beat k = o*IN_DEPTH + d of a pass SHALL carry weight[P_IN*i + j] = W[o*P_OUT + i][d*P_IN + j] (i < P_OUT, j < P_IN). This is the transposed, partitioned order that a fixed_linear consumer accumulates over IN_DEPTH beats.
REQ-005 Memory SHALL be BEATS x BEAT_W, with a synchronous write and a 1-cycle read.
REQ-006 wr_en SHALL be honoured only in IDLE; writes in any other state SHALL be dropped.
REQ-007 The FSM SHALL have the states IDLE, PREFETCH, STREAM and DONE.
- IDLE -> PREFETCH on start with rows != 0.
- IDLE -> DONE on start with rows == 0.
- PREFETCH -> STREAM after one cycle.
- STREAM -> DONE when the final beat of the final row handshakes.
- DONE -> IDLE after one cycle; done is high only in DONE.
REQ-008 start outside IDLE SHALL be ignored.
REQ-009 busy SHALL be high in PREFETCH, STREAM and DONE.
REQ-010 weight_valid SHALL first rise 2 cycles after start is accepted.
REQ-011 With weight_ready held high, the block SHALL sustain one beat per cycle with no bubbles across o, d and row boundaries, using a 2-entry output skid/prefetch buffer.
REQ-012 While weight_valid=1 and weight_ready=0, weight SHALL hold stable and weight_valid SHALL stay high.
REQ-013 Counters SHALL behave as follows:
- d wraps IN_DEPTH-1 -> 0 and increments o.
- o wraps OUT_DEPTH-1 -> 0 and increments the row count.
- Streaming ends when the row count reaches rows.
- All advances occur only on a handshake (weight_valid & weight_ready).
REQ-014 rows > MAX_ROWS SHALL be clamped to MAX_ROWS.
REQ-015 A wr_en in the same cycle as an accepted start SHALL be performed, and the written data SHALL be visible in the stream.

Reset
REQ-016 On rst low, asynchronously: state=IDLE, weight_valid=0, busy=0, done=0, all counters=0, and the skid buffer is emptied.
REQ-017 Weight memory contents SHALL be retained across reset.
REQ-018 A reset asserted mid-stream SHALL drop the in-flight beat. After release, no beat SHALL be emitted until a new start.

Configuration
REQ-019 With macro WEIGHT_SOURCE_LAST_EN defined, an output port weight_last (1 bit) SHALL exist. It is high with weight_valid on every beat with d == IN_DEPTH-1, is held with its beat under backpressure, and resets to 0.
REQ-020 Without WEIGHT_SOURCE_LAST_EN, the weight_last port and its logic SHALL be absent, and behaviour is otherwise identical.

Verification (W=8, DIM_0=4, DIM_1=4, P_OUT=2, P_IN=2, BEATS=4)
REQ-021 Load beats 0..3 with 0x..00/01/02/03 patterns; start rows=1 with ready high -> beats 0,1,2,3 emitted on consecutive cycles, first valid 2 cycles after start, done pulse 1 cycle after beat 3.
REQ-022 rows=3 with ready high -> 12 contiguous beats with sequence 0,1,2,3 repeated, busy high throughout, exactly one done pulse.
REQ-023 Toggle weight_ready 1,0,0,1 -> each beat is held unchanged while stalled, with no loss or duplication over rows=2 (8 beats).
REQ-024 start with rows=0 -> no valid, done pulses 1 cycle later; start during STREAM and wr_en during STREAM -> both ignored, memory unchanged.
REQ-025 rst low at beat 2 of rows=2 -> outputs are zero immediately; after release there is no valid; a new start rows=1 streams beats 0..3 with the pre-reset memory contents.
REQ-026 With WEIGHT_SOURCE_LAST_EN defined -> weight_last is high on beats 1 and 3 of each pass and is held under stall.
